// File: rtl/hdu_sb.sv
// rtl/hdu_sb.sv - hazard detect unit with long-latency register scoreboard
// Drives IF/ID stall and IF/ID/EX flush enables for the 5-stage core.
module hdu_sb #(
    parameter int REG_AW     = 5,
    parameter int MAX_LONG   = 2,
    parameter int TRAP_FLUSH = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [REG_AW-1:0]                id_rs1_addr,
    input  logic [REG_AW-1:0]                id_rs2_addr,
    input  logic                             id_rs1_rd,
    input  logic                             id_rs2_rd,
    input  logic                             id_is_long,
    input  logic                             ex_mem_read,
    input  logic [REG_AW-1:0]                ex_rd_addr,
    input  logic                             issue_long,
    input  logic [REG_AW-1:0]                issue_rd,
    input  logic                             long_done,
    input  logic [REG_AW-1:0]                long_done_rd,
    input  logic                             take_branch,
    input  logic                             trap_take,
    input  logic                             mem_stall,
    output logic                             if_stall,
    output logic                             id_stall,
    output logic                             if_flush,
    output logic                             id_flush,
    output logic                             ex_flush,
    output logic [2**REG_AW-1:0]             sb_busy,
    output logic [$clog2(MAX_LONG+1)-1:0]    long_cnt
);

    localparam int NREG = 2**REG_AW;
    localparam int CW   = $clog2(MAX_LONG+1);
    localparam int TW   = $clog2(TRAP_FLUSH+1);

    typedef enum logic {ST_RUN, ST_TRAP} state_t;

    state_t          state_q;
    logic [TW-1:0]   trap_cnt_q;
    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // The trap_take cycle is the first flush cycle; TRAP covers the remaining TRAP_FLUSH-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_RUN;
            trap_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (trap_take) begin
                        state_q    <= ST_TRAP;
                        trap_cnt_q <= TW'(TRAP_FLUSH - 1);
                    end
                end
                ST_TRAP: begin
                    if (trap_take) begin
                        trap_cnt_q <= TW'(TRAP_FLUSH - 1);
                    end else if (trap_cnt_q <= TW'(1)) begin
                        state_q    <= ST_RUN;
                        trap_cnt_q <= '0;
                    end else begin
                        trap_cnt_q <= trap_cnt_q - TW'(1);
                    end
                end
                default: begin
                    state_q    <= ST_RUN;
                    trap_cnt_q <= '0;
                end
            endcase
        end
    end

    // Clear applied before set so a same-register issue/done pair stays busy.
    always_comb begin
        busy_d = busy_q;
        if (long_done) begin
            busy_d[long_done_rd] = 1'b0;
        end
        if (issue_long && issue_rd != '0) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        cnt_d = cnt_q;
        case ({issue_long, long_done})
            2'b10:   if (cnt_q != CW'(MAX_LONG)) cnt_d = cnt_q + CW'(1);
            2'b01:   if (cnt_q != '0)            cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(long_done && cnt_q == '0));
        end
    end

    logic load_use, rs1_sb, rs2_sb, struct_haz, hazard;

    // A writeback this cycle forwards the result, so its register no longer blocks ID.
    always_comb begin
        load_use   = ex_mem_read && (ex_rd_addr != '0) &&
                     ((id_rs1_rd && id_rs1_addr == ex_rd_addr) ||
                      (id_rs2_rd && id_rs2_addr == ex_rd_addr));
        rs1_sb     = id_rs1_rd && busy_q[id_rs1_addr] &&
                     !(long_done && long_done_rd == id_rs1_addr);
        rs2_sb     = id_rs2_rd && busy_q[id_rs2_addr] &&
                     !(long_done && long_done_rd == id_rs2_addr);
        struct_haz = id_is_long && (cnt_q == CW'(MAX_LONG)) && !long_done;
        hazard     = load_use || rs1_sb || rs2_sb || struct_haz;
    end

    always_comb begin
        if_stall = 1'b0;
        id_stall = 1'b0;
        if_flush = 1'b0;
        id_flush = 1'b0;
        ex_flush = 1'b0;
        if (rst) begin
            if_stall = 1'b0;
        end else if (trap_take || state_q == ST_TRAP) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
            ex_flush = 1'b1;
        end else if (take_branch) begin
            if_flush = 1'b1;
            id_flush = 1'b1;
        end else if (mem_stall) begin
            if_stall = 1'b1;
            id_stall = 1'b1;
        end else if (hazard) begin
            if_stall = 1'b1;
            id_flush = 1'b1;
        end
    end

    assign sb_busy  = busy_q;
    assign long_cnt = cnt_q;

endmodule

// File: tb/tb_hdu_sb.sv
// tb/tb_hdu_sb.sv - directed scoreboard bench for hdu_sb
module tb_hdu_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr, issue_rd, long_done_rd;
    logic        id_rs1_rd, id_rs2_rd, id_is_long, ex_mem_read, issue_long, long_done;
    logic        take_branch, trap_take, mem_stall;
    logic        if_stall, id_stall, if_flush, id_flush, ex_flush;
    logic [31:0] sb_busy;
    logic [1:0]  long_cnt;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [4:0]  ctl;
        logic [31:0] busy;
        logic [1:0]  cnt;
    } exp_t;

    exp_t exp_q[$];

    hdu_sb #(.REG_AW(5), .MAX_LONG(2), .TRAP_FLUSH(2)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_rd(id_rs1_rd), .id_rs2_rd(id_rs2_rd), .id_is_long(id_is_long),
        .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
        .issue_long(issue_long), .issue_rd(issue_rd),
        .long_done(long_done), .long_done_rd(long_done_rd),
        .take_branch(take_branch), .trap_take(trap_take), .mem_stall(mem_stall),
        .if_stall(if_stall), .id_stall(id_stall), .if_flush(if_flush),
        .id_flush(id_flush), .ex_flush(ex_flush),
        .sb_busy(sb_busy), .long_cnt(long_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic clr();
        id_rs1_addr = '0; id_rs2_addr = '0; ex_rd_addr = '0; issue_rd = '0; long_done_rd = '0;
        id_rs1_rd = 0; id_rs2_rd = 0; id_is_long = 0; ex_mem_read = 0;
        issue_long = 0; long_done = 0; take_branch = 0; trap_take = 0; mem_stall = 0;
    endtask

    // ctl order: {if_stall, id_stall, if_flush, id_flush, ex_flush}
    task automatic step(input string tag, input logic [4:0] ctl, input logic [31:0] busy,
                        input logic [1:0] cnt);
        exp_t e, g;
        logic [4:0] got;
        e.tag = tag; e.ctl = ctl; e.busy = busy; e.cnt = cnt;
        exp_q.push_back(e);
        @(negedge clk);
        g = exp_q.pop_front();
        got = {if_stall, id_stall, if_flush, id_flush, ex_flush};
        vectors++;
        assert (got === g.ctl) else begin
            miscompares++;
            $error("FAIL %s ctl: got %b expected %b", g.tag, got, g.ctl);
        end
        vectors++;
        assert (sb_busy === g.busy) else begin
            miscompares++;
            $error("FAIL %s sb_busy: got %h expected %h", g.tag, sb_busy, g.busy);
        end
        vectors++;
        assert (long_cnt === g.cnt) else begin
            miscompares++;
            $error("FAIL %s long_cnt: got %0d expected %0d", g.tag, long_cnt, g.cnt);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr();
        rst = 1'b1;
        step("reset", 5'b00000, 32'h0, 2'd0);
        rst = 1'b0;

        take_branch = 1;                      step("branch", 5'b00110, 32'h0, 2'd0);
        clr();                                step("branch_off", 5'b00000, 32'h0, 2'd0);

        trap_take = 1;                        step("trap0", 5'b00111, 32'h0, 2'd0);
        clr();                                step("trap1", 5'b00111, 32'h0, 2'd0);
                                              step("trap_done", 5'b00000, 32'h0, 2'd0);

        trap_take = 1; take_branch = 1; mem_stall = 1;
                                              step("prio_trap", 5'b00111, 32'h0, 2'd0);
        trap_take = 0; take_branch = 0;       step("prio_trapst", 5'b00111, 32'h0, 2'd0);
                                              step("prio_mem", 5'b11000, 32'h0, 2'd0);
        take_branch = 1;                      step("prio_br", 5'b00110, 32'h0, 2'd0);
        clr();

        ex_mem_read = 1; ex_rd_addr = 5; id_rs2_addr = 5; id_rs2_rd = 1;
                                              step("lu_rs2", 5'b10010, 32'h0, 2'd0);
        ex_rd_addr = 0; id_rs2_addr = 0;      step("lu_x0", 5'b00000, 32'h0, 2'd0);
        ex_rd_addr = 5; id_rs2_addr = 5; id_rs2_rd = 0;
                                              step("lu_noread", 5'b00000, 32'h0, 2'd0);
        id_rs1_addr = 5; id_rs1_rd = 1;       step("lu_rs1", 5'b10010, 32'h0, 2'd0);
        clr();

        issue_long = 1; issue_rd = 7;         step("sb_issue", 5'b00000, 32'h0, 2'd0);
        clr(); id_rs1_addr = 7; id_rs1_rd = 1;
                                              step("sb_stall", 5'b10010, 32'h80, 2'd1);
        mem_stall = 1;                        step("sb_mem", 5'b11000, 32'h80, 2'd1);
        mem_stall = 0; long_done = 1; long_done_rd = 7;
                                              step("sb_bypass", 5'b00000, 32'h80, 2'd1);
        long_done = 0;                        step("sb_clear", 5'b00000, 32'h0, 2'd0);
        clr();

        issue_long = 1; issue_rd = 3;         step("st_iss1", 5'b00000, 32'h0, 2'd0);
        issue_rd = 4;                         step("st_iss2", 5'b00000, 32'h8, 2'd1);
        issue_long = 0; id_is_long = 1;       step("st_full", 5'b10010, 32'h18, 2'd2);
        long_done = 1; long_done_rd = 3;      step("st_done", 5'b00000, 32'h18, 2'd2);
        id_is_long = 0; long_done_rd = 4; issue_long = 1; issue_rd = 6;
                                              step("st_both", 5'b00000, 32'h10, 2'd1);
        issue_long = 0; long_done_rd = 6;     step("st_hold", 5'b00000, 32'h40, 2'd1);
        clr();                                step("st_empty", 5'b00000, 32'h0, 2'd0);

        issue_long = 1; issue_rd = 9;         step("same_iss", 5'b00000, 32'h0, 2'd0);
        long_done = 1; long_done_rd = 9;      step("same_both", 5'b00000, 32'h200, 2'd1);
        long_done = 0; issue_rd = 0;          step("iss_x0", 5'b00000, 32'h200, 2'd1);
        clr(); id_rs1_addr = 9; id_rs1_rd = 1; id_rs2_addr = 0; id_rs2_rd = 1;
                                              step("pre_rst", 5'b10010, 32'h200, 2'd2);
        #2 rst = 1'b1;
        step("async_rst", 5'b00000, 32'h0, 2'd0);
        rst = 1'b0;                           step("post_rst", 5'b00000, 32'h0, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
